alu_share_arbiter: RTL and testbench

Shares one combinational ALU_16 between two requesters, such as the execute stage and the address-generation unit. The block accepts one operation at a time through a valid/ready handshake and picks the winner round-robin. It latches the operands, drives the ALU for one cycle, then holds the result and the z/v/n flags on the winner's response port until that port accepts them. It sits between the pipeline front-ends and the single ALU_16 instance.

---
 rtl/alu_share_arbiter_pkg.sv | 14 +
 rtl/ALU_16.sv | 35 +++
 rtl/alu_rr_grant.sv | 13 +
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: ALU opcodes, widths and arbiter FSM states
package alu_share_arbiter_pkg;
    localparam int ALU_OP_W = 3;
    localparam int ALU_DW   = 16;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'd7;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/ALU_16.sv
// ALU_16: shared 16-bit combinational ALU; n/v only meaningful for add/sub
module ALU_16
    import alu_share_arbiter_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [ALU_DW-1:0]   a,
    input  logic [ALU_DW-1:0]   b,
    output logic [ALU_DW-1:0]   y,
    output logic                z,
    output logic                v,
    output logic                n
);
    logic [ALU_DW-1:0] sum, diff;
    logic arith;
    // compute result and flags; logic ops report n=0 and v=0
    always_comb begin
        sum   = a + b;
        diff  = a - b;
        arith = (op == ALU_ADD) || (op == ALU_SUB);
        case (op)
            ALU_ADD: y = sum;
            ALU_SUB: y = diff;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            ALU_SHL: y = a << b[3:0];
            default: y = a >> b[3:0];
        endcase
        z = (y == '0);
        n = arith ? y[ALU_DW-1] : 1'b0;
        v = (op == ALU_ADD) ? ((a[ALU_DW-1] == b[ALU_DW-1]) && (sum[ALU_DW-1] != a[ALU_DW-1])) :
            (op == ALU_SUB) ? ((a[ALU_DW-1] != b[ALU_DW-1]) && (diff[ALU_DW-1] != a[ALU_DW-1])) : 1'b0;
    end
endmodule

// File: rtl/alu_rr_grant.sv
// alu_rr_grant: one-hot grant between two requesters, round-robin or fixed priority
module alu_rr_grant #(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       last_served,
    output logic [1:0] grant
);
    // a tie goes to the requester not served last, or always to requester 0
    always_comb begin
        grant = (&valid) ? ((FAIR_RR && !last_served) ? 2'b10 : 2'b01) : valid;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU_16 between two requesters with valid/ready handshakes
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter bit FAIR_RR = 1'b1,
    parameter int DW      = ALU_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [DW-1:0]       req0_a,
    input  logic [DW-1:0]       req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [DW-1:0]       req1_a,
    input  logic [DW-1:0]       req1_b,
    output logic                resp0_valid,
    input  logic                resp0_ready,
    output logic [DW-1:0]       resp0_result,
    output logic                resp0_z,
    output logic                resp0_v,
    output logic                resp0_n,
    output logic                resp1_valid,
    input  logic                resp1_ready,
    output logic [DW-1:0]       resp1_result,
    output logic                resp1_z,
    output logic                resp1_v,
    output logic                resp1_n,
    output logic                busy
);
    if (DW != ALU_DW) begin : g_bad_dw
        $error("alu_share_arbiter: DW must be 16 to match ALU_16");
    end

    state_t              state;
    logic [ALU_OP_W-1:0] op_q;
    logic [DW-1:0]       a_q, b_q, alu_y, result;
    logic                alu_z, alu_v, alu_n, z_q, v_q, n_q;
    logic                owner, last_served;
    logic [1:0]          grant, ready, resp_valid;

    alu_rr_grant #(.FAIR_RR(FAIR_RR)) u_grant (
        .valid       ({req1_valid, req0_valid}),
        .last_served (last_served),
        .grant       (grant)
    );

    // the ALU only ever sees latched operands, never the live request ports
    ALU_16 u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y),
        .z  (alu_z),
        .v  (alu_v),
        .n  (alu_n)
    );

    assign ready        = (state == ST_IDLE && rst_n) ? grant : 2'b00;
    assign req0_ready   = ready[0];
    assign req1_ready   = ready[1];
    assign resp0_valid  = resp_valid[0];
    assign resp1_valid  = resp_valid[1];
    assign resp0_result = result;
    assign resp1_result = result;
    assign resp0_z      = z_q;
    assign resp1_z      = z_q;
    assign resp0_v      = v_q;
    assign resp1_v      = v_q;
    assign resp0_n      = n_q;
    assign resp1_n      = n_q;
    assign busy         = (state != ST_IDLE);

    // accept one op, run it through the ALU for a cycle, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            resp_valid  <= 2'b00;
            result      <= '0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (|ready) begin
                    op_q        <= ready[1] ? req1_op : req0_op;
                    a_q         <= ready[1] ? req1_a : req0_a;
                    b_q         <= ready[1] ? req1_b : req0_b;
                    owner       <= ready[1];
                    last_served <= ready[1];
                    state       <= ST_EXEC;
                end
                ST_EXEC: begin
                    result     <= alu_y;
                    z_q        <= alu_z;
                    v_q        <= alu_v;
                    n_q        <= alu_n;
                    resp_valid <= owner ? 2'b10 : 2'b01;
                    state      <= ST_RESP;
                end
                ST_RESP: if (owner ? resp1_ready : resp0_ready) begin
                    resp_valid <= 2'b00;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, latency, backpressure and reset
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic r0_valid, r0_ready, r1_valid, r1_ready;
    logic [2:0] r0_op, r1_op;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic p0_valid, p0_ready, p1_valid, p1_ready;
    logic [15:0] p0_result, p1_result;
    logic p0_z, p0_v, p0_n, p1_z, p1_v, p1_n, busy;

    logic f0_valid, f0_ready, f1_valid, f1_ready;
    logic [2:0] f0_op, f1_op;
    logic [15:0] f0_a, f0_b, f1_a, f1_b;
    logic g0_valid, g0_ready, g1_valid, g1_ready;
    logic [15:0] g0_result, g1_result;
    logic g0_z, g0_v, g0_n, g1_z, g1_v, g1_n, f_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.FAIR_RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
        .resp0_valid(p0_valid), .resp0_ready(p0_ready), .resp0_result(p0_result),
        .resp0_z(p0_z), .resp0_v(p0_v), .resp0_n(p0_n),
        .resp1_valid(p1_valid), .resp1_ready(p1_ready), .resp1_result(p1_result),
        .resp1_z(p1_z), .resp1_v(p1_v), .resp1_n(p1_n),
        .busy(busy)
    );

    alu_share_arbiter #(.FAIR_RR(1'b0)) fdut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_op(f0_op), .req0_a(f0_a), .req0_b(f0_b),
        .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_op(f1_op), .req1_a(f1_a), .req1_b(f1_b),
        .resp0_valid(g0_valid), .resp0_ready(g0_ready), .resp0_result(g0_result),
        .resp0_z(g0_z), .resp0_v(g0_v), .resp0_n(g0_n),
        .resp1_valid(g1_valid), .resp1_ready(g1_ready), .resp1_result(g1_result),
        .resp1_z(g1_z), .resp1_v(g1_v), .resp1_n(g1_n),
        .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 0; r0_op = '0; r0_a = '0; r0_b = '0;
        r1_valid = 0; r1_op = '0; r1_a = '0; r1_b = '0;
        p0_ready = 0; p1_ready = 0;
        f0_valid = 0; f0_op = '0; f0_a = '0; f0_b = '0;
        f1_valid = 0; f1_op = '0; f1_a = '0; f1_b = '0;
        g0_ready = 1; g1_ready = 1;
        #11;
        r0_valid = 1;
        #1;
        chk("rst_ready0", r0_ready, 0);
        chk("rst_ready1", r1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp0_valid", p0_valid, 0);
        chk("rst_resp1_valid", p1_valid, 0);
        chk("rst_result", p0_result, 0);
        chk("rst_flags", {p0_z, p0_v, p0_n}, 0);
        r0_valid = 0;
        #10;
        rst_n = 1'b1;

        // XOR basic on requester 0
        r0_op = ALU_XOR; r0_a = 16'h0003; r0_b = 16'h0005; r0_valid = 1; p0_ready = 1; p1_ready = 1;
        #1;
        chk("xor_ready0", r0_ready, 1);
        chk("xor_ready1", r1_ready, 0);
        tick();
        r0_valid = 0;
        chk("xor_exec_busy", busy, 1);
        chk("xor_exec_valid", p0_valid, 0);
        chk("xor_exec_ready0", r0_ready, 0);
        tick();
        chk("xor_resp0_valid", p0_valid, 1);
        chk("xor_result", p0_result, 16'h0006);
        chk("xor_flags", {p0_z, p0_v, p0_n}, 3'b000);
        chk("xor_resp1_valid", p1_valid, 0);
        tick();
        chk("xor_done_valid", p0_valid, 0);
        chk("xor_done_busy", busy, 0);

        // XOR to zero on requester 1
        r1_op = ALU_XOR; r1_a = 16'hFFFF; r1_b = 16'hFFFF; r1_valid = 1;
        #1;
        chk("zero_ready1", r1_ready, 1);
        chk("zero_ready0", r0_ready, 0);
        tick();
        r1_valid = 0;
        tick();
        chk("zero_resp1_valid", p1_valid, 1);
        chk("zero_result", p1_result, 16'h0000);
        chk("zero_flags", {p1_z, p1_v, p1_n}, 3'b100);
        chk("zero_resp0_valid", p0_valid, 0);
        tick();
        chk("zero_done_valid", p1_valid, 0);

        // signed overflow on add: 0x7FFF + 1
        r0_op = ALU_ADD; r0_a = 16'h7FFF; r0_b = 16'h0001; r0_valid = 1;
        #1;
        chk("add_ready0", r0_ready, 1);
        tick();
        r0_valid = 0;
        tick();
        chk("add_result", p0_result, 16'h8000);
        chk("add_flags", {p0_z, p0_v, p0_n}, 3'b011);
        tick();

        // reset during EXEC discards the op and restores last_served
        r0_op = ALU_XOR; r0_a = 16'h1234; r0_b = 16'h0000; r0_valid = 1;
        #1;
        tick();
        r0_valid = 0;
        chk("rmid_exec_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_resp0_valid", p0_valid, 0);
        chk("rmid_result", p0_result, 0);
        chk("rmid_flags", {p0_z, p0_v, p0_n}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmid_post_valid0", p0_valid, 0);
        chk("rmid_post_busy", busy, 0);
        tick();
        chk("rmid_post2_valid0", p0_valid, 0);

        // contention: grants alternate 0,1,0,1
        r0_op = ALU_XOR; r0_a = 16'hFFFF; r0_b = 16'h0000; r0_valid = 1;
        r1_op = ALU_XOR; r1_a = 16'h0003; r1_b = 16'h0005; r1_valid = 1;
        #1;
        chk("cont1_ready0", r0_ready, 1);
        chk("cont1_ready1", r1_ready, 0);
        tick();
        tick();
        chk("cont1_resp0_valid", p0_valid, 1);
        chk("cont1_result", p0_result, 16'hFFFF);
        chk("cont1_flags", {p0_z, p0_v, p0_n}, 3'b000);
        chk("cont1_resp1_valid", p1_valid, 0);
        tick();
        chk("cont2_ready1", r1_ready, 1);
        chk("cont2_ready0", r0_ready, 0);
        tick();
        tick();
        chk("cont2_resp1_valid", p1_valid, 1);
        chk("cont2_result", p1_result, 16'h0006);
        chk("cont2_resp0_valid", p0_valid, 0);
        tick();
        chk("cont3_ready0", r0_ready, 1);
        chk("cont3_ready1", r1_ready, 0);
        tick();
        tick();
        tick();
        chk("cont4_ready1", r1_ready, 1);
        chk("cont4_ready0", r0_ready, 0);
        r0_valid = 0;
        tick();
        r1_valid = 0;
        tick();
        tick();
        chk("cont_end_busy", busy, 0);

        // backpressure on resp0 with requester 1 waiting
        r0_op = ALU_XOR; r0_a = 16'h00F0; r0_b = 16'h0F0F; r0_valid = 1; p0_ready = 0;
        #1;
        chk("bp_ready0", r0_ready, 1);
        tick();
        r0_valid = 0;
        r1_op = ALU_XOR; r1_a = 16'h8000; r1_b = 16'h0001; r1_valid = 1;
        #1;
        chk("bp_exec_ready1", r1_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", p0_valid, 1);
            chk("bp_hold_result", p0_result, 16'h0FFF);
            chk("bp_hold_flags", {p0_z, p0_v, p0_n}, 3'b000);
            chk("bp_hold_busy", busy, 1);
            chk("bp_hold_readies", {r1_ready, r0_ready}, 2'b00);
            chk("bp_hold_resp1", p1_valid, 0);
            tick();
        end
        p0_ready = 1;
        #1;
        chk("bp_release_ready1", r1_ready, 0);
        tick();
        chk("bp_after_ready1", r1_ready, 1);
        chk("bp_after_valid0", p0_valid, 0);
        tick();
        r1_valid = 0;
        tick();
        chk("bp_r1_valid", p1_valid, 1);
        chk("bp_r1_result", p1_result, 16'h8001);
        chk("bp_r1_flags", {p1_z, p1_v, p1_n}, 3'b000);
        tick();
        chk("bp_end_busy", busy, 0);

        // fixed priority: requester 0 always wins
        f0_op = ALU_XOR; f0_a = 16'h0003; f0_b = 16'h0005; f0_valid = 1;
        f1_op = ALU_XOR; f1_a = 16'h0001; f1_b = 16'h0001; f1_valid = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fix_ready0", f0_ready, 1);
            chk("fix_ready1", f1_ready, 0);
            tick();
            tick();
            chk("fix_resp0_valid", g0_valid, 1);
            chk("fix_resp1_valid", g1_valid, 0);
            chk("fix_result", g0_result, 16'h0006);
            tick();
        end
        f0_valid = 0;
        f1_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
